// File: rtl/serial_cmp_6bit.sv
// Bit-serial unsigned magnitude comparator: scans latched operands LSB-first, one bit per clock,
// and reports the selected relation (GTE/LT/EQ/NE) in X[0] with a start/busy/done handshake.
module serial_cmp_6bit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [5:0]       X
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [1:0]       sop;
  logic [CW-1:0]    cnt;
  logic             gt, eq;
  logic             gt_nxt, eq_nxt;
  logic             res;
  logic             x_bit;
  logic             accept;
  logic             last_bit;

  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (state == SCAN) && (cnt == LAST);

  // Later bits are more significant, so any difference seen now overrides earlier ones.
  always_comb begin
    gt_nxt = (sa[0] != sb[0]) ? sa[0] : gt;
    eq_nxt = eq & (sa[0] == sb[0]);
  end

  always_comb begin
    res = 1'b0;
    unique case (sop)
      2'b00: res = gt_nxt | eq_nxt;
      2'b01: res = ~(gt_nxt | eq_nxt);
      2'b10: res = eq_nxt;
      2'b11: res = ~eq_nxt;
      default: res = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sop   <= '0;
      cnt   <= '0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      x_bit <= 1'b0;
    end else if (accept) begin
      sa  <= A;
      sb  <= B;
      sop <= op;
      cnt <= '0;
      gt  <= 1'b0;
      eq  <= 1'b1;
    end else if (state == SCAN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      cnt <= cnt + 1'b1;
      gt  <= gt_nxt;
      eq  <= eq_nxt;
      if (last_bit) x_bit <= res;
    end
  end

  assign X = {5'b0, x_bit};

endmodule
